// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: first-word-fall-through FIFO of committed CPU instructions with cycle stamps.
// Define TRACE_WRAP_EN to overwrite the oldest entry when full instead of dropping the new one.
module cpu_trace_buffer #(
   parameter int unsigned DEPTH = 16,
   parameter logic [2:0] COMMIT_STT = 3'd0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [63:0]              pc_in,
   input  logic [31:0]              opcode_in,
   input  logic [2:0]               stt_in,
   input  logic [63:0]              ula_in,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [63:0]              rd_pc,
   output logic [31:0]              rd_opcode,
   output logic [63:0]              rd_ula,
   output logic [31:0]              rd_stamp,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   logic [63:0] pc_mem [DEPTH];
   logic [31:0] op_mem [DEPTH];
   logic [63:0] ula_mem [DEPTH];
   logic [31:0] st_mem [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0] stamp_q;
   logic [2:0] prev_q;
   logic ovf_q;
   logic evt, pop, full, ovw, inc, wr_en, adv;
   assign evt = enable && stt_in == COMMIT_STT && prev_q != COMMIT_STT;
   assign pop = rd_valid && rd_ready;
   assign full = cnt_q == CW'(DEPTH);
   assign ovw = evt && full && !pop;
   assign inc = evt && !ovw;
`ifdef TRACE_WRAP_EN
   // when full the write slot is the head, so both pointers move together
   assign wr_en = evt;
   assign adv = pop || ovw;
`else
   assign wr_en = inc;
   assign adv = pop;
`endif
   assign wp_d = wr_en ? wp_q + AW'(1) : wp_q;
   assign rp_d = adv ? rp_q + AW'(1) : rp_q;
   assign cnt_d = cnt_q + CW'(inc) - CW'(pop);
   always_ff @(posedge clock) begin
      if (reset) begin
         stamp_q <= '0;
         prev_q  <= COMMIT_STT;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (clear) begin
         stamp_q <= '0;
         prev_q  <= stt_in;
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         stamp_q <= stamp_q + 32'd1;
         prev_q  <= stt_in;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_q || ovw;
      end
   end
   always_ff @(posedge clock) begin
      if (wr_en && !reset && !clear) begin
         pc_mem[wp_q]  <= pc_in;
         op_mem[wp_q]  <= opcode_in;
         ula_mem[wp_q] <= ula_in;
         st_mem[wp_q]  <= stamp_q;
      end
   end
   assign rd_valid  = cnt_q != '0;
   assign rd_pc     = pc_mem[rp_q];
   assign rd_opcode = op_mem[rp_q];
   assign rd_ula    = ula_mem[rp_q];
   assign rd_stamp  = st_mem[rp_q];
   assign count     = cnt_q;
   assign overflow  = ovf_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed table-driven check of a 16-deep and a 4-deep trace buffer
module tb_cpu_trace_buffer;
   logic clock = 1'b0;
   logic reset, enable, clear, rdy, srdy;
   logic [63:0] pc;
   logic [2:0] stt;
   logic rd_valid, overflow, s_valid, s_overflow;
   logic [63:0] rd_pc, rd_ula, s_pc, s_ula;
   logic [31:0] rd_opcode, rd_stamp, s_opcode, s_stamp;
   logic [4:0] count;
   logic [2:0] s_count;
   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] stamp_m = 32'd0;
   logic [31:0] edge_st;
   logic [31:0] st [8];
   typedef struct {
      logic [2:0] stt;
      logic [63:0] pc;
      logic en;
      logic rdy;
      logic ev;
      logic [4:0] ec;
      logic [63:0] epc;
      logic [31:0] es;
   } vec_t;
   vec_t tv[$];
   always #5 clock = ~clock;
   cpu_trace_buffer #(.DEPTH(16), .COMMIT_STT(3'd0)) dut (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .pc_in(pc), .opcode_in(opc_of(pc)), .stt_in(stt), .ula_in(~pc),
      .rd_ready(rdy), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_opcode(rd_opcode),
      .rd_ula(rd_ula), .rd_stamp(rd_stamp), .count(count), .overflow(overflow));
   cpu_trace_buffer #(.DEPTH(4), .COMMIT_STT(3'd0)) sdut (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .pc_in(pc), .opcode_in(opc_of(pc)), .stt_in(stt), .ula_in(~pc),
      .rd_ready(srdy), .rd_valid(s_valid), .rd_pc(s_pc), .rd_opcode(s_opcode),
      .rd_ula(s_ula), .rd_stamp(s_stamp), .count(s_count), .overflow(s_overflow));
   function automatic logic [31:0] opc_of(input logic [63:0] p);
      return 32'hA500_0000 ^ p[31:0];
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc(input logic [2:0] s, input logic [63:0] p, input logic e,
                      input logic r, input logic sr, input logic c);
      stt = s; pc = p; enable = e; rdy = r; srdy = sr; clear = c;
      edge_st = stamp_m;
      @(posedge clock);
      #1;
      stamp_m = (reset || c) ? 32'd0 : stamp_m + 32'd1;
      rdy = 1'b0; srdy = 1'b0; clear = 1'b0;
   endtask
   task automatic add(input logic [2:0] s, input logic [63:0] p, input logic e, input logic r,
                      input logic ev, input logic [4:0] ec, input logic [63:0] epc, input logic [31:0] es);
      vec_t v;
      v.stt = s; v.pc = p; v.en = e; v.rdy = r; v.ev = ev; v.ec = ec; v.epc = epc; v.es = es;
      tv.push_back(v);
   endtask
   task automatic ev_cycle(input logic [63:0] p);
      cyc(3'd0, p, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(3'd1, p, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask
   initial begin
      reset = 1'b1; enable = 1'b1; clear = 1'b0; rdy = 1'b0; srdy = 1'b0; stt = 3'd0; pc = '0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_count", count, 0);
      chk("reset_valid", rd_valid, 0);
      chk("reset_ovf", overflow, 0);
      chk("reset_s_count", s_count, 0);
      reset = 1'b0;
      stamp_m = 32'd0;
      add(3'd0, 64'h0, 1, 0, 0, 0, 0, 0);
      add(3'd1, 64'h0, 1, 0, 0, 0, 0, 0);
      add(3'd2, 64'h0, 1, 0, 0, 0, 0, 0);
      add(3'd0, 64'h4, 1, 0, 1, 1, 64'h4, 3);
      add(3'd1, 64'h4, 1, 0, 1, 1, 64'h4, 3);
      add(3'd2, 64'h8, 1, 1, 0, 0, 0, 0);
      for (int f = 0; f < 5; f++) begin
         add(3'd0, 64'h40 + 64'(f), 0, 0, 0, 0, 0, 0);
         add(3'd1, 64'h40 + 64'(f), 0, 0, 0, 0, 0, 0);
         add(3'd2, 64'h40 + 64'(f), 0, 0, 0, 0, 0, 0);
      end
      add(3'd1, 64'h100, 1, 0, 0, 0, 0, 0);
      add(3'd2, 64'h100, 1, 0, 0, 0, 0, 0);
      add(3'd0, 64'h100, 1, 0, 1, 1, 64'h100, 23);
      add(3'd1, 64'h104, 1, 1, 0, 0, 0, 0);
      for (int i = 0; i < tv.size(); i++) begin
         cyc(tv[i].stt, tv[i].pc, tv[i].en, tv[i].rdy, 1'b0, 1'b0);
         chk($sformatf("tv%0d_count", i), count, tv[i].ec);
         chk($sformatf("tv%0d_valid", i), rd_valid, tv[i].ev);
         if (tv[i].ev) begin
            chk($sformatf("tv%0d_pc", i), rd_pc, tv[i].epc);
            chk($sformatf("tv%0d_opc", i), rd_opcode, opc_of(tv[i].epc));
            chk($sformatf("tv%0d_ula", i), rd_ula, ~tv[i].epc);
            chk($sformatf("tv%0d_stamp", i), rd_stamp, tv[i].es);
         end
      end
      for (int k = 0; k < 8; k++) begin
         cyc(3'd0, 64'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0);
         st[k] = edge_st;
         cyc(3'd1, 64'(4 * k), 1'b1, 1'b0, 1'b0, 1'b0);
      end
      chk("burst_count", count, 8);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("burst_pc%0d", k), rd_pc, 64'(4 * k));
         chk($sformatf("burst_stamp%0d", k), rd_stamp, st[k]);
         if (k > 0) chk($sformatf("burst_incr%0d", k), 64'(st[k] > st[k-1]), 1);
         cyc(3'd1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("burst_empty", count, 0);
      chk("burst_valid", rd_valid, 0);
      cyc(3'd1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("clr_s_ovf", s_overflow, 0);
      chk("clr_s_count", s_count, 0);
      for (int k = 0; k < 4; k++) ev_cycle(64'(4 * k));
      chk("full_s_count", s_count, 4);
      chk("full_s_ovf", s_overflow, 0);
      cyc(3'd0, 64'h10, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("same_edge_count", s_count, 4);
      chk("same_edge_ovf", s_overflow, 0);
      cyc(3'd1, 64'h10, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("same_edge_pc%0d", k), s_pc, 64'(4 * (k + 1)));
         cyc(3'd1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      chk("same_edge_drain", s_count, 0);
      cyc(3'd1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) ev_cycle(64'(4 * k));
      chk("ovf_count", s_count, 4);
      chk("ovf_flag", s_overflow, 1);
      for (int k = 0; k < 4; k++) begin
`ifdef TRACE_WRAP_EN
         chk($sformatf("ovf_head%0d", k), s_pc, 64'(8 + 4 * k));
`else
         chk($sformatf("ovf_head%0d", k), s_pc, 64'(4 * k));
`endif
         cyc(3'd1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      chk("ovf_sticky", s_overflow, 1);
      chk("ovf_drain", s_count, 0);
      cyc(3'd1, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) ev_cycle(64'h180 + 64'(4 * k));
      chk("pre_clr_count", count, 3);
      cyc(3'd0, 64'h200, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("clr_ev_count", count, 0);
      chk("clr_ev_valid", rd_valid, 0);
      chk("clr_ev_ovf", overflow, 0);
      cyc(3'd0, 64'h204, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("clr_no_event", count, 0);
      cyc(3'd1, 64'h204, 1'b1, 1'b0, 1'b0, 1'b0);
      ev_cycle(64'h280);
      ev_cycle(64'h284);
      chk("pre_rst_count", count, 2);
      reset = 1'b1;
      cyc(3'd0, 64'h288, 1'b1, 1'b1, 1'b0, 1'b0);
      reset = 1'b0;
      chk("rst_mid_count", count, 0);
      chk("rst_mid_valid", rd_valid, 0);
      cyc(3'd0, 64'h28c, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_in_commit", count, 0);
      cyc(3'd1, 64'h28c, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(3'd0, 64'h300, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("post_rst_count", count, 1);
      chk("post_rst_pc", rd_pc, 64'h300);
      chk("post_rst_stamp", rd_stamp, 32'd2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
